// File: rtl/four_bool_scorer.sv
// ---------------------------------------------------------------------------
// four_bool_scorer
//
// Purpose:
//   Stimulus and checking end for an evolved 4-input/4-output boolean circuit.
//   On start it walks every input vector v = 0 .. NV-1. Each vector is held on
//   dut_in for SETTLE_CYCLES clocks so the candidate's gates can settle. It is
//   then held for one more SAMPLE clock, in which dut_out is compared against
//   a latched copy of the target truth table. The block accumulates a
//   bit-match score and a per-vector mismatch map, which the evolution loop
//   uses as fitness.
//
// Handshake:
//   start is a level sampled only in IDLE. A high start at a clock edge in
//   IDLE begins one evaluation. At any other time start is ignored. done is a
//   one-cycle pulse. score and vec_mismatch become valid with done and stay
//   valid until the next accepted start or reset.
//
// Ports:
//   clk           in   1         rising-edge clock
//   rst_n         in   1         asynchronous active-low reset
//   start         in   1         begin evaluation (IDLE only)
//   target_table  in   NV*N_OUT  bit [v*N_OUT+k] = expected output k of vector v
//   dut_in        out  N_IN      vector applied to the candidate circuit
//   dut_out       in   N_OUT     candidate circuit outputs
//   busy          out  1         high through all SETTLE/SAMPLE cycles
//   done          out  1         one-cycle result-valid pulse
//   score         out  SW        number of matching output bits over all vectors
//   vec_mismatch  out  NV        bit v set if any output of vector v mismatched
//   dbg_state     out  2         current FSM state, for checkers
// ---------------------------------------------------------------------------
module four_bool_scorer #(
    parameter int N_IN          = 4,
    parameter int N_OUT         = 4,
    parameter int SETTLE_CYCLES = 4,
    localparam int NV           = 2 ** N_IN,
    localparam int SW           = $clog2(NV * N_OUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NV*N_OUT-1:0]   target_table,
    output logic [N_IN-1:0]       dut_in,
    input  logic [N_OUT-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [SW-1:0]         score,
    output logic [NV-1:0]         vec_mismatch,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // +1 keeps the counter at least one bit wide when SETTLE_CYCLES == 1.
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    logic [1:0]            state;
    logic [N_IN-1:0]       vec;
    logic [CW-1:0]         cnt;
    logic [NV*N_OUT-1:0]   tbl;

    logic [N_OUT-1:0]      exp_bits;
    logic [N_OUT-1:0]      match;
    logic [SW-1:0]         match_cnt;
    logic                  vec_bad;

    assign dbg_state = state;

    // Number of set bits in the match vector. It is at most N_OUT, so it
    // always fits in SW bits.
    function automatic logic [SW-1:0] popcount(input logic [N_OUT-1:0] bits);
        logic [SW-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_OUT; i++) begin
            acc = acc + SW'(bits[i]);
        end
        return acc;
    endfunction

    // Compare logic. It is only consumed in SAMPLE, so whatever dut_out
    // does during SETTLE has no effect.
    always_comb begin
        exp_bits  = tbl[int'(vec) * N_OUT +: N_OUT];
        match     = ~(dut_out ^ exp_bits);
        match_cnt = popcount(match);
        vec_bad   = ~&match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            vec          <= '0;
            cnt          <= '0;
            tbl          <= '0;
            dut_in       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            score        <= '0;
            vec_mismatch <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Latch the table so later changes to target_table
                        // cannot disturb the evaluation in flight.
                        tbl          <= target_table;
                        score        <= '0;
                        vec_mismatch <= '0;
                        vec          <= '0;
                        cnt          <= '0;
                        dut_in       <= '0;
                        busy         <= 1'b1;
                        state        <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    score             <= score + match_cnt;
                    vec_mismatch[vec] <= vec_bad;
                    if (vec == VEC_LAST) begin
                        // done and busy are registered here so that they
                        // line up exactly with the DONE state.
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        dut_in <= '0;
                        state  <= ST_DONE;
                    end else begin
                        vec    <= vec + 1'b1;
                        dut_in <= vec + 1'b1;
                        cnt    <= '0;
                        state  <= ST_SETTLE;
                    end
                end

                ST_DONE: begin
                    // A start held high here is seen on the next IDLE cycle.
                    vec   <= '0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_four_bool_scorer.sv
module tb_four_bool_scorer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int NV    = 16;
    localparam int SW    = 7;
    localparam int DONE_AT = 81;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                start = 1'b0;
    logic [NV*N_OUT-1:0] target_table = '0;
    logic [N_IN-1:0]     dut_in;
    logic [N_OUT-1:0]    dut_out;
    logic                busy;
    logic                done;
    logic [SW-1:0]       score;
    logic [NV-1:0]       vec_mismatch;
    logic [1:0]          dbg_state;

    // 0 = loopback, 1 = inverted loopback
    int mode = 0;
    always_comb dut_out = (mode == 0) ? dut_in : ~dut_in;

    four_bool_scorer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .target_table (target_table),
        .dut_in       (dut_in),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .score        (score),
        .vec_mismatch (vec_mismatch),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Raise start for exactly one edge (e0), then count negedges: negedge n
    // falls between edges n-1 and n. Optionally pulse start at n=10 and n=40
    // and scramble target_table after e0.
    task automatic run_eval(input string name, input int m, input logic [63:0] tbl,
                            input bit pulses, output int done_cycle, output int done_count);
        mode         = m;
        target_table = tbl;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (pulses) target_table = ~tbl;
        done_cycle = -1;
        done_count = 0;
        for (int n = 1; n <= 95; n++) begin
            @(negedge clk);
            start = pulses && (n == 10 || n == 40);
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = n;
            end
            if (n == 1) begin
                check({name, "_busy_c1"}, 64'(busy), 64'd1);
                check({name, "_dut_in_c1"}, 64'(dut_in), 64'd0);
            end
            if (n == 6)  check({name, "_dut_in_c6"}, 64'(dut_in), 64'd1);
            if (n == 80) check({name, "_dut_in_c80"}, 64'(dut_in), 64'd15);
            if (n == 81) begin
                check({name, "_busy_c81"}, 64'(busy), 64'd0);
                check({name, "_dut_in_c81"}, 64'(dut_in), 64'd0);
            end
        end
        start = 1'b0;
        check({name, "_done_cycle"}, 64'(done_cycle), 64'(DONE_AT));
        check({name, "_done_count"}, 64'(done_count), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    int dc, dn;
    bit seen7;

    initial begin
        // 1: reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dut_in", 64'(dut_in), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_score", 64'(score), 64'd0);
        check("rst_vec_mismatch", 64'(vec_mismatch), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: loopback, matching table -> every bit matches
        run_eval("loop_id", 0, 64'hFEDCBA9876543210, 1'b0, dc, dn);
        check("loop_id_score", 64'(score), 64'd64);
        check("loop_id_mismatch", 64'(vec_mismatch), 64'h0000);

        // 3: loopback vs all-zero table -> matches = 64 - 32 ones
        run_eval("loop_zero", 0, 64'h0, 1'b0, dc, dn);
        check("loop_zero_score", 64'(score), 64'd32);
        check("loop_zero_mismatch", 64'(vec_mismatch), 64'hFFFE);

        // 4: inverted loopback -> nothing matches
        run_eval("inv", 1, 64'hFEDCBA9876543210, 1'b0, dc, dn);
        check("inv_score", 64'(score), 64'd0);
        check("inv_mismatch", 64'(vec_mismatch), 64'hFFFF);
        // results hold in IDLE
        repeat (5) @(negedge clk);
        check("inv_score_hold", 64'(score), 64'd0);

        // 5: start pulses mid-run and table changes are ignored
        run_eval("pulse", 0, 64'hFEDCBA9876543210, 1'b1, dc, dn);
        check("pulse_score", 64'(score), 64'd64);
        check("pulse_mismatch", 64'(vec_mismatch), 64'h0000);

        // 6: async reset mid-run while dut_in=7, then full restart
        mode = 0;
        target_table = 64'hFEDCBA9876543210;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen7 = 1'b0;
        for (int n = 0; n < 60 && !seen7; n++) begin
            @(negedge clk);
            if (dut_in == 4'd7) seen7 = 1'b1;
        end
        check("rst_mid_reached_7", 64'(seen7), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_dut_in", 64'(dut_in), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_score", 64'(score), 64'd0);
        check("rst_mid_vec_mismatch", 64'(vec_mismatch), 64'h0);
        check("rst_mid_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_eval("after_rst", 0, 64'hFEDCBA9876543210, 1'b0, dc, dn);
        check("after_rst_score", 64'(score), 64'd64);
        check("after_rst_mismatch", 64'(vec_mismatch), 64'h0000);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
